// File: rtl/awb_gain.sv
// rtl/awb_gain.sv - per-channel white-balance gain stage with frame statistics (optional: AWB_STATS_EN)
module awb_gain #(
  parameter int H        = 1280,
  parameter int V        = 720,
  parameter int STAT_SAT = 250
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        pix_valid_in,
  input  logic [23:0] pix_data_in,
  input  logic        sof_in,
  input  logic [7:0]  gain_r,
  input  logic [7:0]  gain_g,
  input  logic [7:0]  gain_b,
  input  logic        gain_update,
  output logic        pix_valid_out,
  output logic [23:0] pix_data_out,
  output logic        sof_out,
  output logic [31:0] stat_sum_r,
  output logic [31:0] stat_sum_g,
  output logic [31:0] stat_sum_b,
  output logic [31:0] stat_cnt,
  output logic        stat_valid,
  output logic        frame_err
);

  localparam int CW = (H > 1) ? $clog2(H) : 1;
  localparam int RW = (V > 1) ? $clog2(V) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(H - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(V - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-1:0] eff_col;
  logic [RW-1:0] eff_row;
  logic          sof_acc;
  logic          at_origin;

  // A start-of-frame pixel is always treated as position (0,0)
  always_comb begin
    sof_acc   = pix_valid_in & sof_in;
    eff_col   = sof_acc ? '0 : col;
    eff_row   = sof_acc ? '0 : row;
    at_origin = (col == '0) && (row == '0);
  end

  // Position counters and frame-structure check
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col       <= '0;
      row       <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (pix_valid_in) begin
        frame_err <= sof_in ? !at_origin : at_origin;
        if (eff_col == COL_LAST) begin
          col <= '0;
          row <= (eff_row == ROW_LAST) ? '0 : eff_row + 1'b1;
        end else begin
          col <= eff_col + 1'b1;
          row <= eff_row;
        end
      end
    end
  end

  logic [7:0] act_r, act_g, act_b;
  logic [7:0] shd_r, shd_g, shd_b;
  logic       pend;
  logic [7:0] use_r, use_g, use_b;

  // Gains applied to the current pixel: only a start-of-frame pixel may switch them
  always_comb begin
    use_r = act_r;
    use_g = act_g;
    use_b = act_b;
    if (sof_acc) begin
      if (gain_update) begin
        use_r = gain_r;
        use_g = gain_g;
        use_b = gain_b;
      end else if (pend) begin
        use_r = shd_r;
        use_g = shd_g;
        use_b = shd_b;
      end
    end
  end

  // Shadow/active gain registers; a pending update waits for the next frame start
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      act_r <= 8'd64;
      act_g <= 8'd64;
      act_b <= 8'd64;
      shd_r <= 8'd64;
      shd_g <= 8'd64;
      shd_b <= 8'd64;
      pend  <= 1'b0;
    end else begin
      if (gain_update) begin
        shd_r <= gain_r;
        shd_g <= gain_g;
        shd_b <= gain_b;
      end
      if (sof_acc) begin
        act_r <= use_r;
        act_g <= use_g;
        act_b <= use_b;
        pend  <= 1'b0;
      end else if (gain_update) begin
        pend  <= 1'b1;
      end
    end
  end

  logic [15:0] p_r, p_g, p_b;
  logic        v1, s1;

  // Stage 1: raw Q2.6 products
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p_r <= '0;
      p_g <= '0;
      p_b <= '0;
      v1  <= 1'b0;
      s1  <= 1'b0;
    end else begin
      v1 <= pix_valid_in;
      s1 <= sof_acc;
      p_r <= 16'(pix_data_in[23:16]) * 16'(use_r);
      p_g <= 16'(pix_data_in[15:8])  * 16'(use_g);
      p_b <= 16'(pix_data_in[7:0])   * 16'(use_b);
    end
  end

  // Round to nearest and saturate to 8 bits; 255*255+32 still fits in 16 bits
  function automatic logic [7:0] round_clip(input logic [15:0] p);
    logic [15:0] s;
    logic [9:0]  q;
    s = p + 16'd32;
    q = s[15:6];
    return (q > 10'd255) ? 8'hFF : q[7:0];
  endfunction

  // Stage 2: rounded/clipped output, data held while no pixel is valid
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pix_valid_out <= 1'b0;
      sof_out       <= 1'b0;
      pix_data_out  <= '0;
    end else begin
      pix_valid_out <= v1;
      sof_out       <= v1 & s1;
      if (v1) begin
        pix_data_out <= {round_clip(p_r), round_clip(p_g), round_clip(p_b)};
      end
    end
  end

`ifdef AWB_STATS_EN
  localparam logic [8:0] SAT = 9'(STAT_SAT);

  logic [31:0] acc_r, acc_g, acc_b, acc_c;
  logic [31:0] sum_r, sum_g, sum_b, sum_c;
  logic        incl;
  logic        at_last;

  // Running totals including the current pixel; a frame start discards earlier totals
  always_comb begin
    incl    = ({1'b0, pix_data_in[23:16]} < SAT) &&
              ({1'b0, pix_data_in[15:8]}  < SAT) &&
              ({1'b0, pix_data_in[7:0]}   < SAT);
    at_last = (eff_col == COL_LAST) && (eff_row == ROW_LAST);
    sum_r   = (sof_acc ? 32'd0 : acc_r) + (incl ? 32'(pix_data_in[23:16]) : 32'd0);
    sum_g   = (sof_acc ? 32'd0 : acc_g) + (incl ? 32'(pix_data_in[15:8])  : 32'd0);
    sum_b   = (sof_acc ? 32'd0 : acc_b) + (incl ? 32'(pix_data_in[7:0])   : 32'd0);
    sum_c   = (sof_acc ? 32'd0 : acc_c) + (incl ? 32'd1 : 32'd0);
  end

  // Accumulate per frame; publish and clear on the last pixel of the frame
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_r      <= '0;
      acc_g      <= '0;
      acc_b      <= '0;
      acc_c      <= '0;
      stat_sum_r <= '0;
      stat_sum_g <= '0;
      stat_sum_b <= '0;
      stat_cnt   <= '0;
      stat_valid <= 1'b0;
    end else begin
      stat_valid <= 1'b0;
      if (pix_valid_in) begin
        if (at_last) begin
          stat_sum_r <= sum_r;
          stat_sum_g <= sum_g;
          stat_sum_b <= sum_b;
          stat_cnt   <= sum_c;
          stat_valid <= 1'b1;
          acc_r      <= '0;
          acc_g      <= '0;
          acc_b      <= '0;
          acc_c      <= '0;
        end else begin
          acc_r <= sum_r;
          acc_g <= sum_g;
          acc_b <= sum_b;
          acc_c <= sum_c;
        end
      end
    end
  end
`else
  logic [8:0] unused_stat_sat;
  assign unused_stat_sat = 9'(STAT_SAT);
  assign stat_sum_r = '0;
  assign stat_sum_g = '0;
  assign stat_sum_b = '0;
  assign stat_cnt   = '0;
  assign stat_valid = 1'b0;
`endif

endmodule

// File: tb/tb_awb_gain.sv
// tb/tb_awb_gain.sv - randomized self-checking bench for awb_gain against a frame-level reference model
module tb_awb_gain;
  localparam int H = 4;
  localparam int V = 2;
  localparam int N = H * V;

`ifdef AWB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        pix_valid_in = 1'b0;
  logic [23:0] pix_data_in = '0;
  logic        sof_in = 1'b0;
  logic [7:0]  gain_r = '0, gain_g = '0, gain_b = '0;
  logic        gain_update = 1'b0;
  logic        pix_valid_out;
  logic [23:0] pix_data_out;
  logic        sof_out;
  logic [31:0] stat_sum_r, stat_sum_g, stat_sum_b, stat_cnt;
  logic        stat_valid;
  logic        frame_err;

  always #5 clk = ~clk;

  awb_gain #(.H(H), .V(V), .STAT_SAT(250)) dut (
    .clk(clk), .rstn(rstn),
    .pix_valid_in(pix_valid_in), .pix_data_in(pix_data_in), .sof_in(sof_in),
    .gain_r(gain_r), .gain_g(gain_g), .gain_b(gain_b), .gain_update(gain_update),
    .pix_valid_out(pix_valid_out), .pix_data_out(pix_data_out), .sof_out(sof_out),
    .stat_sum_r(stat_sum_r), .stat_sum_g(stat_sum_g), .stat_sum_b(stat_sum_b),
    .stat_cnt(stat_cnt), .stat_valid(stat_valid), .frame_err(frame_err)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  int          m_pos;
  int          m_ar, m_ag, m_ab, m_sr, m_sg, m_sb;
  bit          m_pend;
  int          a_r, a_g, a_b, a_c;
  bit          p1_v, p1_s;
  logic [23:0] p1_d;
  bit          e_v, e_s, e_fe, e_sv;
  logic [23:0] e_d;
  int          e_sr, e_sg, e_sb, e_sc;

  function automatic int gclip(input int x, input int g);
    int q;
    q = (x * g + 32) / 64;
    return (q > 255) ? 255 : q;
  endfunction

  function automatic logic [23:0] rpix();
    logic [23:0] p;
    for (int c = 0; c < 3; c++) begin
      p[c*8 +: 8] = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(245, 255)) : 8'($urandom);
    end
    return p;
  endfunction

  task automatic model_reset();
    m_pos = 0; m_pend = 0;
    m_ar = 64; m_ag = 64; m_ab = 64; m_sr = 64; m_sg = 64; m_sb = 64;
    a_r = 0; a_g = 0; a_b = 0; a_c = 0;
    p1_v = 0; p1_s = 0; p1_d = '0;
    e_v = 0; e_s = 0; e_fe = 0; e_sv = 0; e_d = '0;
    e_sr = 0; e_sg = 0; e_sb = 0; e_sc = 0;
  endtask

  task automatic check_all();
    chk("pix_valid_out", pix_valid_out, e_v);
    chk("sof_out", sof_out, e_s);
    chk("pix_data_out", pix_data_out, e_d);
    chk("frame_err", frame_err, e_fe);
    chk("stat_valid", stat_valid, STATS ? e_sv : 1'b0);
    chk("stat_sum_r", stat_sum_r, STATS ? e_sr : 0);
    chk("stat_sum_g", stat_sum_g, STATS ? e_sg : 0);
    chk("stat_sum_b", stat_sum_b, STATS ? e_sb : 0);
    chk("stat_cnt", stat_cnt, STATS ? e_sc : 0);
  endtask

  // one clock: drive at negedge, advance model, check at the following negedge
  task automatic apply(input bit v, input bit s, input logic [23:0] d,
                       input bit gu, input logic [7:0] gr, input logic [7:0] gg, input logic [7:0] gb);
    bit fe = 0, sv = 0;
    logic [23:0] od = '0;
    int r, g, b, sr = 0, sg = 0, sb = 0, sc = 0;
    pix_valid_in = v; sof_in = v & s; pix_data_in = d; gain_update = gu;
    gain_r = gu ? gr : 8'($urandom);
    gain_g = gu ? gg : 8'($urandom);
    gain_b = gu ? gb : 8'($urandom);
    r = int'(d[23:16]); g = int'(d[15:8]); b = int'(d[7:0]);
    if (v) begin
      if (s) begin
        fe = (m_pos != 0);
        m_pos = 0;
        if (gu) begin m_ar = gr; m_ag = gg; m_ab = gb; end
        else if (m_pend) begin m_ar = m_sr; m_ag = m_sg; m_ab = m_sb; end
        if (gu) begin m_sr = gr; m_sg = gg; m_sb = gb; end
        m_pend = 0;
        a_r = 0; a_g = 0; a_b = 0; a_c = 0;
      end else begin
        fe = (m_pos == 0);
        if (gu) begin m_sr = gr; m_sg = gg; m_sb = gb; m_pend = 1; end
      end
      od = {8'(gclip(r, m_ar)), 8'(gclip(g, m_ag)), 8'(gclip(b, m_ab))};
      if (r < 250 && g < 250 && b < 250) begin
        a_r += r; a_g += g; a_b += b; a_c++;
      end
      if (m_pos == N - 1) begin
        sv = 1; sr = a_r; sg = a_g; sb = a_b; sc = a_c;
        a_r = 0; a_g = 0; a_b = 0; a_c = 0;
      end
      m_pos = (m_pos + 1) % N;
    end else if (gu) begin
      m_sr = gr; m_sg = gg; m_sb = gb; m_pend = 1;
    end
    @(posedge clk);
    e_v = p1_v;
    e_s = p1_v & p1_s;
    if (p1_v) e_d = p1_d;
    p1_v = v; p1_s = s; p1_d = od;
    e_fe = fe;
    e_sv = sv;
    if (sv) begin e_sr = sr; e_sg = sg; e_sb = sb; e_sc = sc; end
    @(negedge clk);
    check_all();
  endtask

  task automatic px(input bit s, input logic [23:0] d);
    apply(1'b1, s, d, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 24'd0, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic gupd(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    apply(1'b0, 1'b0, 24'd0, 1'b1, r, g, b);
  endtask

  task automatic do_reset();
    rstn = 1'b0; pix_valid_in = 1'b0; sof_in = 1'b0; gain_update = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    rstn = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    repeat (2) idle();

    // unity gains pass-through, sof_out alignment
    px(1'b1, 24'h804010);
    for (int i = 1; i < N; i++) px(1'b0, rpix());
    repeat (2) idle();
    chk("unity_data", pix_data_out, 24'h804010 == 24'h804010 ? e_d : 24'h0);

    // clip and rounding
    gupd(8'd128, 8'd64, 8'd32);
    px(1'b1, 24'hFF6503);
    idle();
    chk("clip_round", pix_data_out, 32'h00FF6502);
    for (int i = 1; i < N; i++) px(1'b0, rpix());

    // mid-frame update must wait for the next frame start
    gupd(8'd64, 8'd64, 8'd64);
    px(1'b1, rpix());
    px(1'b0, rpix());
    apply(1'b1, 1'b0, 24'h404040, 1'b1, 8'd96, 8'd64, 8'd64);
    for (int i = 3; i < N; i++) px(1'b0, 24'h404040);
    idle();
    chk("midframe_hold", pix_data_out, 32'h00404040);
    px(1'b1, 24'h404040);
    idle();
    chk("next_frame_gain", pix_data_out, 32'h00604040);
    for (int i = 1; i < N; i++) px(1'b0, rpix());

    // statistics with one saturated pixel
    gupd(8'd64, 8'd64, 8'd64);
    for (int i = 0; i < N; i++) px(i == 0, (i == 5) ? 24'hFA0000 : 24'h0A141E);
`ifdef AWB_STATS_EN
    chk("stat_pulse", stat_valid, 1'b1);
    chk("stat_r70", stat_sum_r, 32'd70);
    chk("stat_g140", stat_sum_g, 32'd140);
    chk("stat_b210", stat_sum_b, 32'd210);
    chk("stat_cnt7", stat_cnt, 32'd7);
`endif
    idle();

    // sof injected at (2,0): aborted frame, then realigned frame completes
    px(1'b1, rpix());
    px(1'b0, rpix());
    px(1'b1, rpix());
    for (int i = 1; i < N; i++) px(1'b0, rpix());
    idle();

    // reset mid-frame, then a clean frame
    gupd(8'd90, 8'd70, 8'd50);
    px(1'b1, rpix());
    px(1'b0, rpix());
    px(1'b0, rpix());
    do_reset();
    for (int i = 0; i < N; i++) px(i == 0, rpix());
    repeat (2) idle();

    // frame without sof lands at (0,0)
    for (int i = 0; i < N; i++) px(1'b0, rpix());
    idle();

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 2) == 0) gupd(8'($urandom), 8'($urandom), 8'($urandom));
          else idle();
        end
        apply(1'b1, (i == 0) || ($urandom_range(0, 30) == 0), rpix(),
              $urandom_range(0, 7) == 0, 8'($urandom), 8'($urandom), 8'($urandom));
      end
    end
    repeat (3) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
